// File: rtl/pipe_pkg.sv
// Shared constants for every elastic pipeline stage register in the core.
// Width pairs per stage boundary keep the control unit and the stage instances in agreement.
package pipe_pkg;

   // Bubble = every control bit deasserted, i.e. a NOP travelling down the pipe.
   localparam int CTRL_MAX_W = 32;
   localparam logic [CTRL_MAX_W-1:0] BUBBLE_CTRL = '0;

   localparam int IFID_CTRL_W  = 8;
   localparam int IFID_DATA_W  = 96;
   localparam int IDEX_CTRL_W  = 16;
   localparam int IDEX_DATA_W  = 208;
   localparam int EXMEM_CTRL_W = 8;
   localparam int EXMEM_DATA_W = 133;
   localparam int MEMWB_CTRL_W = 4;
   localparam int MEMWB_DATA_W = 69;

   localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry skid slot: valid flag plus control/data payload, with load and clear.
// Clear wins over load; the payload only changes on load so a stale value is harmless.
module pipe_skid_slot #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= in_ctrl;
         data  <= in_data;
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with ready/valid backpressure, 1-entry skid slot,
// hazard stall, flush, and a saturating count of cycles the output sat unaccepted.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int CTRL_W      = 8,
   parameter int DATA_W      = 64,
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter bit ZERO_BUBBLE = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic [CTRL_W-1:0] BUBBLE  = CTRL_W'(BUBBLE_CTRL);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   // Handshake: an item moves across a boundary on a cycle where valid and ready are
   // both high. Downstream readiness is out_ready_i gated by ~stall_i; upstream readiness
   // is the registered ~skid_valid, so no combinational path runs from out_ready_i/stall_i
   // to in_ready_o.
   logic              eff_ready;
   logic              out_acc;
   logic              in_acc;
   logic              main_free;

   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              skid_load;
   logic              skid_clear;

   logic              main_valid;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CNT_W-1:0]  stall_cnt;

   assign in_ready_o = ~skid_valid;
   assign eff_ready  = out_ready_i & ~stall_i;
   assign out_acc    = main_valid & eff_ready;
   assign in_acc     = in_valid_i & in_ready_o;
   assign main_free  = ~main_valid | out_acc;

   // Skid only catches an item when main is occupied and not moving on this cycle.
   assign skid_load  = in_acc & ~main_free & ~flush_i;
   assign skid_clear = flush_i | (main_free & skid_valid);

   pipe_skid_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load    (skid_load),
      .clear   (skid_clear),
      .in_ctrl (in_ctrl_i),
      .in_data (in_data_i),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .data    (skid_data)
   );

   // Skid has priority into main so items leave in arrival order; while the skid is
   // full in_ready_o is low, so skid and input never compete for main.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_valid <= 1'b0;
         main_ctrl  <= BUBBLE;
         main_data  <= '0;
      end else if (flush_i) begin
         main_valid <= 1'b0;
         main_ctrl  <= BUBBLE;
      end else if (main_free) begin
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
         end else if (in_acc) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl_i;
            main_data  <= in_data_i;
         end else begin
            main_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
      end else if (main_valid && !eff_ready && !flush_i && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign out_valid_o = main_valid;
   assign out_ctrl_o  = (ZERO_BUBBLE && !main_valid) ? BUBBLE : main_ctrl;
   assign out_data_o  = main_data;
   assign stall_cnt_o = stall_cnt;

endmodule
